oam_dma_bus_ctrl: RTL and testbench

- Sits directly downstream of the CPU bus interface (phi, a, dout, din, rd, wr) and upstream of the system memory bus.
- Implements the OAM DMA register at 0xFF46, which copies 160 bytes from {src_hi,0x00} to OAM at 0xFE00–0xFE9F, one byte per M-cycle.
- Owns the 127-byte HRAM (0xFF80–0xFFFE), so the CPU can keep executing from HRAM while DMA holds the system bus.
- Outside DMA it is a transparent pass-through between the CPU bus and the system bus.

---
 rtl/oam_dma_bus_ctrl_pkg.sv | 33 +++
 rtl/oam_dma_bus_ctrl_if.sv | 34 +++
 rtl/oam_dma_bus_ctrl_hram.sv | 39 +++
 rtl/oam_dma_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_oam_dma_bus_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_bus_ctrl_pkg.sv
// Shared constants, state encoding and source-page helper for the OAM DMA bus controller.
// Optional feature macro: OAM_DMA_ECHO_REMAP_EN (echo-RAM source page remap).
package oam_dma_bus_ctrl_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned PHASE_W    = 2;
    localparam int unsigned HRAM_AW    = 7;
    localparam int unsigned DMA_LEN    = 160;
    localparam int unsigned HRAM_DEPTH = 127;

    localparam logic [ADDR_W-1:0] ADDR_DMA  = 16'hFF46;
    localparam logic [ADDR_W-1:0] HRAM_BASE = 16'hFF80;
    localparam logic [ADDR_W-1:0] HRAM_LAST = 16'hFFFE;
    localparam logic [ADDR_W-1:0] OAM_BASE  = 16'hFE00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } dma_state_e;

    // Page actually driven on the system bus for a given FF46 value.
    function automatic logic [DATA_W-1:0] dma_src_page(input logic [DATA_W-1:0] src_hi);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return (src_hi >= 8'hE0) ? DATA_W'(src_hi - 8'h20) : src_hi;
`else
        return src_hi;
`endif
    endfunction

endpackage

// File: rtl/oam_dma_bus_ctrl_if.sv
// CPU-side, system-side and OAM-side bus signals of the OAM DMA bus controller.
interface oam_dma_bus_ctrl_if;

    logic        cpu_phi;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] sys_a;
    logic [7:0]  sys_dout;
    logic [7:0]  sys_din;
    logic        sys_rd;
    logic        sys_wr;
    logic [7:0]  oam_a;
    logic [7:0]  oam_dout;
    logic        oam_wr;
    logic        dma_active;

    // Controller side.
    modport slave (
        input  cpu_phi, cpu_a, cpu_dout, cpu_rd, cpu_wr, sys_din,
        output cpu_din, sys_a, sys_dout, sys_rd, sys_wr,
        output oam_a, oam_dout, oam_wr, dma_active
    );

    // CPU / memory / OAM environment side.
    modport master (
        output cpu_phi, cpu_a, cpu_dout, cpu_rd, cpu_wr, sys_din,
        input  cpu_din, sys_a, sys_dout, sys_rd, sys_wr,
        input  oam_a, oam_dout, oam_wr, dma_active
    );

endinterface

// File: rtl/oam_dma_bus_ctrl_hram.sv
// 127x8 high RAM: synchronous write, registered read; contents are not reset.
module oam_dma_bus_ctrl_hram
    import oam_dma_bus_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [HRAM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [HRAM_DEPTH];
    logic [DATA_W-1:0] mem_d [HRAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              addr_ok_c;

    // Next array contents and read data; index 127 is outside the array.
    always_comb begin
        mem_d     = mem_q;
        addr_ok_c = (addr_i < HRAM_AW'(HRAM_DEPTH));
        rdata_d   = '0;
        if (addr_ok_c) begin
            rdata_d = mem_q[addr_i];
            if (we_i) begin
                mem_d[addr_i] = wdata_i;
            end
        end
    end

    // Array and read-data registers.
    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/oam_dma_bus_ctrl.sv
// OAM DMA register (FF46), HRAM owner and CPU/system bus arbiter.
// Optional feature macro: OAM_DMA_ECHO_REMAP_EN (E0-FF source pages read from C0-DF).
module oam_dma_bus_ctrl
    import oam_dma_bus_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    oam_dma_bus_ctrl_if.slave bus
);

    dma_state_e          state_q, state_d;
    logic [DATA_W-1:0]   src_hi_q, src_hi_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                phi_q, phi_d;
    logic                oam_wr_q, oam_wr_d;
    logic [IDX_W-1:0]    oam_a_q, oam_a_d;
    logic [DATA_W-1:0]   oam_dout_q, oam_dout_d;

    logic                phi_rise_c;
    logic [PHASE_W-1:0]  cur_phase_c;
    logic                hit_hram_c;
    logic                hit_dma_c;
    logic                local_c;
    logic                ff46_wr_c;
    logic                dma_active_c;
    logic [HRAM_AW-1:0]  hram_addr_c;
    logic                hram_we_c;
    logic [DATA_W-1:0]   hram_rdata;

    logic [ADDR_W-1:0]   sys_a_c;
    logic [DATA_W-1:0]   sys_dout_c;
    logic                sys_rd_c;
    logic                sys_wr_c;
    logic [DATA_W-1:0]   cpu_din_c;

    // M-cycle phase tracking: a phi rising edge forces phase 0 in that clk.
    always_comb begin
        phi_d       = bus.cpu_phi;
        phi_rise_c  = bus.cpu_phi && !phi_q;
        cur_phase_c = phi_rise_c ? '0 : phase_q;
        phase_d     = PHASE_W'(cur_phase_c + PHASE_W'(1));
    end

    // CPU address decode for the locally served regions.
    always_comb begin
        hit_hram_c   = (bus.cpu_a >= HRAM_BASE) && (bus.cpu_a <= HRAM_LAST);
        hit_dma_c    = (bus.cpu_a == ADDR_DMA);
        local_c      = hit_hram_c || hit_dma_c;
        ff46_wr_c    = bus.cpu_wr && hit_dma_c;
        hram_we_c    = bus.cpu_wr && hit_hram_c;
        hram_addr_c  = HRAM_AW'(bus.cpu_a - HRAM_BASE);
        dma_active_c = (state_q == ACTIVE);
    end

    // DMA sequencer: next state, byte index, source latch and OAM write port.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        src_hi_d   = src_hi_q;
        oam_wr_d   = 1'b0;
        oam_a_d    = oam_a_q;
        oam_dout_d = oam_dout_q;

        case (state_q)
            IDLE: begin
                idx_d = '0;
            end
            START: begin
                // Enter ACTIVE so that its first clk is a phase-0 clk.
                if (cur_phase_c == PHASE_W'(3)) begin
                    state_d = ACTIVE;
                    idx_d   = '0;
                end
            end
            ACTIVE: begin
                // Byte captured at phase 2 is presented to OAM during phase 3.
                if (cur_phase_c == PHASE_W'(2)) begin
                    oam_wr_d   = 1'b1;
                    oam_a_d    = idx_q;
                    oam_dout_d = bus.sys_din;
                end
                if (cur_phase_c == PHASE_W'(3)) begin
                    if (idx_q == IDX_W'(DMA_LEN - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // A register write restarts from any state; an OAM write already queued still goes out.
        if (ff46_wr_c) begin
            src_hi_d = bus.cpu_dout;
            state_d  = START;
            idx_d    = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_hi_q   <= '0;
            idx_q      <= '0;
            phase_q    <= '0;
            phi_q      <= 1'b0;
            oam_wr_q   <= 1'b0;
            oam_a_q    <= '0;
            oam_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            src_hi_q   <= src_hi_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            phi_q      <= phi_d;
            oam_wr_q   <= oam_wr_d;
            oam_a_q    <= oam_a_d;
            oam_dout_q <= oam_dout_d;
        end
    end

    // Bus ownership: DMA drives the system bus while active, otherwise pass-through.
    always_comb begin
        sys_a_c    = bus.cpu_a;
        sys_dout_c = bus.cpu_dout;
        sys_rd_c   = bus.cpu_rd && !local_c;
        sys_wr_c   = bus.cpu_wr && !local_c;
        cpu_din_c  = bus.sys_din;

        if (dma_active_c) begin
            sys_a_c    = {dma_src_page(src_hi_q), idx_q};
            sys_dout_c = '0;
            sys_rd_c   = (cur_phase_c == PHASE_W'(0)) || (cur_phase_c == PHASE_W'(1));
            sys_wr_c   = 1'b0;
            cpu_din_c  = 8'hFF;
        end

        if (hit_hram_c) begin
            cpu_din_c = hram_rdata;
        end else if (hit_dma_c) begin
            cpu_din_c = src_hi_q;
        end
    end

    oam_dma_bus_ctrl_hram u_hram (
        .clk     (clk),
        .we_i    (hram_we_c),
        .addr_i  (hram_addr_c),
        .wdata_i (bus.cpu_dout),
        .rdata_o (hram_rdata)
    );

    assign bus.sys_a      = sys_a_c;
    assign bus.sys_dout   = sys_dout_c;
    assign bus.sys_rd     = sys_rd_c;
    assign bus.sys_wr     = sys_wr_c;
    assign bus.cpu_din    = cpu_din_c;
    assign bus.oam_a      = oam_a_q;
    assign bus.oam_dout   = oam_dout_q;
    assign bus.oam_wr     = oam_wr_q;
    assign bus.dma_active = dma_active_c;

endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// Scoreboard bench for oam_dma_bus_ctrl: stimulus pushes expected OAM writes,
// DMA source reads and active-window lengths; monitors pop and compare.
module tb_oam_dma_bus_ctrl;
    import oam_dma_bus_ctrl_pkg::*;

    typedef struct {
        logic [15:0] oam_addr;
        logic [7:0]  data;
    } oam_exp_t;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_pass;
    int   n_check;

    oam_exp_t    oam_q[$];
    logic [15:0] sys_q[$];
    int          run_q[$];

    logic [7:0] hram_ref [HRAM_DEPTH];
    bit         hram_vld [HRAM_DEPTH];

    oam_dma_bus_ctrl_if bus ();

    oam_dma_bus_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // System memory model: byte at address A is A[7:0]^0x5A.
    assign bus.sys_din = bus.sys_a[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Reference: source page seen on the system bus for an FF46 value.
    function automatic logic [7:0] ref_page(input logic [7:0] v);
`ifdef OAM_DMA_ECHO_REMAP_EN
        if (v >= 8'hE0) return v - 8'h20;
`endif
        return v;
    endfunction

    function automatic bit ref_local(input logic [15:0] a);
        return (a == 16'hFF46) || (a >= 16'hFF80 && a <= 16'hFFFE);
    endfunction

    task automatic push_transfer(input logic [7:0] v);
        oam_exp_t e;
        for (int i = 0; i < int'(DMA_LEN); i++) begin
            e.oam_addr = OAM_BASE + 16'(i);
            e.data     = 8'(i) ^ 8'h5A;
            oam_q.push_back(e);
            sys_q.push_back({ref_page(v), 8'(i)});
        end
        run_q.push_back(4 * int'(DMA_LEN));
    endtask

    // Cut the pending transfer: keep bytes up to last_oam / reads up to last_sys.
    task automatic truncate(input int last_oam, input int last_sys, input int run_len);
        logic [15:0] s;
        while (oam_q.size() > 0 && oam_q[$].oam_addr > OAM_BASE + 16'(last_oam)) void'(oam_q.pop_back());
        while (sys_q.size() > 0) begin
            s = sys_q[$];
            if (int'(s[7:0]) > last_sys) void'(sys_q.pop_back());
            else break;
        end
        if (run_q.size() > 0) void'(run_q.pop_back());
        run_q.push_back(run_len);
    endtask

    // OAM write monitor.
    always @(negedge clk) begin
        oam_exp_t e;
        if (mon_en && bus.oam_wr) begin
            if (oam_q.size() == 0) begin
                check("oam_wr_unexpected", 32'(bus.oam_a), 32'hFFFF_FFFF);
            end else begin
                e = oam_q.pop_front();
                check("oam_addr", 32'(OAM_BASE + 16'(bus.oam_a)), 32'(e.oam_addr));
                check("oam_dout", 32'(bus.oam_dout), 32'(e.data));
            end
        end
    end

    // DMA source-read monitor: one read per M-cycle, on the sys_rd rise.
    logic prev_rd;
    always @(negedge clk) begin
        logic [15:0] a;
        if (mon_en) begin
            if (bus.dma_active && bus.sys_rd && !prev_rd) begin
                if (sys_q.size() == 0) begin
                    check("sys_rd_unexpected", 32'(bus.sys_a), 32'hFFFF_FFFF);
                end else begin
                    a = sys_q.pop_front();
                    check("dma_sys_a", 32'(bus.sys_a), 32'(a));
                end
            end
            prev_rd <= bus.dma_active && bus.sys_rd;
        end else begin
            prev_rd <= 1'b0;
        end
    end

    // Active-window length monitor.
    int run_cnt;
    always @(negedge clk) begin
        int r;
        if (mon_en) begin
            if (bus.dma_active === 1'b1) begin
                run_cnt <= run_cnt + 1;
            end else if (run_cnt > 0) begin
                r = (run_q.size() > 0) ? run_q.pop_front() : -1;
                check("dma_active_len", 32'(run_cnt), 32'(r));
                run_cnt <= 0;
            end
        end else begin
            run_cnt <= 0;
        end
    end

    // Free-running CPU phi: 4 clk per M-cycle.
    initial begin
        int cnt;
        cnt = 0;
        bus.cpu_phi = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.cpu_phi = (cnt < 2);
            cnt = (cnt + 1) % 4;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_a = a; bus.cpu_dout = d; bus.cpu_wr = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        bus.cpu_a = a; bus.cpu_rd = 1'b1;
        tick();
        @(negedge clk);
        d = bus.cpu_din;
        tick();
        bus.cpu_rd = 1'b0;
    endtask

    task automatic hram_rand_rw();
        int i;
        logic [7:0] d, r;
        i = $urandom_range(0, int'(HRAM_DEPTH) - 1);
        d = 8'($urandom);
        cpu_write(HRAM_BASE + 16'(i), d);
        hram_ref[i] = d; hram_vld[i] = 1'b1;
        cpu_read(HRAM_BASE + 16'(i), r);
        check("hram_readback", 32'(r), 32'(hram_ref[i]));
    endtask

    task automatic wait_pulse(input int idx);
        bit found;
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (bus.oam_wr && int'(bus.oam_a) == idx) found = 1;
        end
        check("wait_pulse_found", 32'(found), 32'd1);
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            if (oam_q.size() == 0 && run_q.size() == 0 && sys_q.size() == 0 && !bus.dma_active) done = 1;
        end
        check("transfer_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [7:0]  r, v;
        logic [15:0] tbl [6];
        bit          loc;

        n_pass = 0; n_check = 0; mon_en = 1'b0;
        bus.cpu_a = '0; bus.cpu_dout = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        for (int i = 0; i < int'(HRAM_DEPTH); i++) hram_vld[i] = 1'b0;
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state.
        cpu_read(ADDR_DMA, r);
        check("reset_ff46", 32'(r), 32'h00);
        check("reset_dma_active", 32'(bus.dma_active), 32'd0);
        check("reset_oam_wr", 32'(bus.oam_wr), 32'd0);

        // Idle pass-through and local-region decode.
        tbl[0] = 16'hC123; tbl[1] = 16'hFFFF; tbl[2] = 16'hFF7F;
        tbl[3] = 16'hFF80; tbl[4] = 16'hFFFE; tbl[5] = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            loc = ref_local(tbl[i]);
            bus.cpu_a = tbl[i]; bus.cpu_rd = 1'b1;
            @(negedge clk);
            check("idle_sys_a", 32'(bus.sys_a), 32'(tbl[i]));
            check("idle_sys_rd", 32'(bus.sys_rd), 32'(!loc));
            if (!loc) check("idle_cpu_din", 32'(bus.cpu_din), 32'(tbl[i][7:0] ^ 8'h5A));
            tick();
            bus.cpu_rd = 1'b0;
            v = 8'($urandom);
            bus.cpu_dout = v; bus.cpu_wr = 1'b1;
            @(negedge clk);
            check("idle_sys_wr", 32'(bus.sys_wr), 32'(!loc));
            if (!loc) check("idle_sys_dout", 32'(bus.sys_dout), 32'(v));
            tick();
            bus.cpu_wr = 1'b0;
            if (tbl[i] >= HRAM_BASE && tbl[i] <= HRAM_LAST) begin
                hram_ref[int'(tbl[i] - HRAM_BASE)] = v;
                hram_vld[int'(tbl[i] - HRAM_BASE)] = 1'b1;
            end
        end
        cpu_read(16'hFFFE, r);
        check("hram_top_byte", 32'(r), 32'(hram_ref[126]));
        repeat (4) hram_rand_rw();

        // Basic transfer from 0xC1 with CPU activity during the DMA.
        cpu_write(ADDR_DMA, 8'hC1);
        push_transfer(8'hC1);
        repeat (12) tick();
        check("active_after_start", 32'(bus.dma_active), 32'd1);
        cpu_read(16'hC000, r);
        check("dma_blocked_read", 32'(r), 32'hFF);
        bus.cpu_a = 16'hC000; bus.cpu_dout = 8'h12; bus.cpu_wr = 1'b1;
        @(negedge clk);
        check("dma_blocked_write", 32'(bus.sys_wr), 32'd0);
        tick();
        bus.cpu_wr = 1'b0;
        cpu_write(16'hFF80, 8'h3C);
        hram_ref[0] = 8'h3C;
        cpu_read(16'hFF80, r);
        check("dma_hram_rw", 32'(r), 32'h3C);
        cpu_read(ADDR_DMA, r);
        check("dma_ff46_read", 32'(r), 32'hC1);
        wait_done();

        // Restart at idx 50, landing in the same clk as the phase-3 OAM write.
        v = 8'($urandom);
        cpu_write(ADDR_DMA, v);
        push_transfer(v);
        wait_pulse(49);
        repeat (4) tick();
        bus.cpu_a = ADDR_DMA; bus.cpu_dout = 8'hD0; bus.cpu_wr = 1'b1;
        truncate(50, 50, 51 * 4);
        push_transfer(8'hD0);
        tick();
        bus.cpu_wr = 1'b0;
        wait_done();

        // Echo-range source page.
        cpu_write(ADDR_DMA, 8'hE2);
        push_transfer(8'hE2);
        cpu_read(ADDR_DMA, r);
        check("echo_ff46_read", 32'(r), 32'hE2);
        wait_done();

        // Random-source transfers with HRAM traffic alongside.
        for (int t = 0; t < 2; t++) begin
            v = 8'($urandom);
            cpu_write(ADDR_DMA, v);
            push_transfer(v);
            repeat (3) hram_rand_rw();
            wait_done();
        end

        // Reset in the phase-0 clk of idx 80.
        v = 8'($urandom);
        cpu_write(ADDR_DMA, v);
        push_transfer(v);
        wait_pulse(79);
        tick();
        rst = 1'b1;
        truncate(79, 80, 80 * 4 + 1);
        tick();
        rst = 1'b0;
        bus.cpu_a = 16'h1234;
        @(negedge clk);
        check("rst_dma_active", 32'(bus.dma_active), 32'd0);
        check("rst_oam_wr", 32'(bus.oam_wr), 32'd0);
        check("rst_passthrough", 32'(bus.sys_a), 32'h1234);
        tick();
        repeat (20) tick();
        check("rst_oam_q_empty", 32'(oam_q.size()), 32'd0);
        check("rst_sys_q_empty", 32'(sys_q.size()), 32'd0);
        check("rst_run_q_empty", 32'(run_q.size()), 32'd0);
        cpu_read(ADDR_DMA, r);
        check("rst_ff46", 32'(r), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
